product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream stage for the signed/unsigned N×N multiplier. It consumes a stream of 2N-bit products over a valid/ready handshake and accumulates each group of products, delimited by a `last` flag, into a wider accumulator. For every group it emits the sum, the beat count and status flags. It is the accumulate half of the team's MAC datapath.

## Interface
- `n`, default 8: multiplier operand width; incoming products are `2*n` bits.
- `acc_w`, default `2*n+8`: accumulator and result width; must be at least `2*n+1`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  `2*n`  product bits, as produced by the multiplier.
- `in_signed`  in  1  1 = `in_prod` is two's complement; 0 = unsigned.
- `in_last`  in  1  final beat of the current group.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `acc_w`  group sum.
- `out_count`  out  8  beats in the group; saturates at 255.
- `out_overflow`  out  1  sticky: at least one add in the group overflowed.
- `out_mixed`  out  1  sticky: the group contained beats of both signedness.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Two-state FSM:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Extension, per beat: `in_prod` is sign-extended to `acc_w` if that beat's `in_signed`=1, otherwise zero-extended.
- Group mode = `in_signed` of the group's first beat, latched at that beat.
- A later beat whose `in_signed` differs from the group mode sets `mixed`.
- On each accepted beat: `acc <= acc + ext(in_prod)`; count increments, saturating at 255.
- Overflow detection uses the group mode:
  - unsigned mode: carry out of bit `acc_w-1`.
  - signed mode: operands have the same sign and the result sign differs.
- On overflow, the sticky `overflow` bit is set; the accumulator wraps modulo 2^`acc_w` unless saturation is compiled in.
- Accepted beat with `in_last`=1:
  - the final sum, count, overflow and mixed (including that beat's contribution) are loaded into the output registers;
  - the accumulator, count and sticky flags clear;
  - FSM goes to HOLD.
- HOLD to ACCUM when `out_valid && out_ready`.
- Single-beat group (`in_last` on the first beat) is legal: `out_count`=1.
- Count 0 is never emitted.

## Timing
- Reset (async assert, sync-safe deassert): FSM=ACCUM; `in_ready`=1; `out_valid`=0; `out_sum`=0; `out_count`=0; `out_overflow`=0; `out_mixed`=0; accumulator, count and flags = 0.
- Throughput in ACCUM: one beat per cycle.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so it is visible the following cycle.
- Output registers hold stable while `out_valid && !out_ready`.
- The next beat can be accepted in the cycle after the output handshake, so there is a minimum one-cycle bubble per group.
- `in_ready` is a registered function of FSM state only; it has no combinational path from `out_ready`.
- Reset during ACCUM or HOLD discards any partial group and any pending result; no output is produced for it.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined: on overflow the accumulator clamps instead of wrapping.
  - unsigned mode: all ones.
  - signed mode: most-positive value if the addend is non-negative, otherwise most-negative.
  - Accumulation continues from the clamped value; `out_overflow` is still set.
- Undefined: wrap-around modulo 2^`acc_w`. Flags behave identically in both builds.

## Test plan
All scenarios use `n`=4, `acc_w`=12.
- Unsigned group: three beats of 8'hE1 (225), `in_signed`=0, last on the third → `out_sum`=675, `out_count`=3, `out_overflow`=0, `out_mixed`=0, `out_valid` one cycle after the third beat.
- Signed group: 8'hC8 (-56), 8'hC8, 8'h40 (64), `in_signed`=1 → `out_sum`=12'hFD0 (-48), `out_count`=3, no flags.
- Unsigned overflow: 19 beats of 8'hE1 → `out_sum`=179 and `out_overflow`=1 without the macro; `out_sum`=12'hFFF and `out_overflow`=1 with `PRODUCT_ACC_SATURATE_EN`.
- Mixed signedness: 8'hFF unsigned then 8'hFF signed with last → `out_sum`=254, `out_mixed`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after the result → `out_valid` and outputs stable, `in_ready`=0, offered beats not consumed; result is taken on `out_ready`=1 and the next group starts clean.
- Reset mid-group: two beats accepted, pulse `rst_n` low asynchronously → all outputs 0 immediately; a following single beat 8'h05 with last → `out_sum`=5, `out_count`=1.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle for product_accumulator: product stream in, group result out.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface product_accumulator_if #(
   parameter int n     = 8,
   parameter int acc_w = 2*n + 8
);
   logic               in_valid;
   logic               in_ready;
   logic [2*n-1:0]     in_prod;
   logic               in_signed;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [acc_w-1:0]   out_sum;
   logic [7:0]         out_count;
   logic               out_overflow;
   logic               out_mixed;

   modport slave (
      input  in_valid, in_prod, in_signed, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_overflow, out_mixed
   );

   modport master (
      output in_valid, in_prod, in_signed, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_overflow, out_mixed
   );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates last-delimited groups of multiplier products into a wide sum with count/overflow/mixed flags.
// Optional build macro PRODUCT_ACC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module product_accumulator #(
   parameter int n     = 8,
   parameter int acc_w = 2*n + 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   product_accumulator_if.slave bus
);

   localparam int EXT_W = acc_w - 2*n;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [acc_w-1:0]   acc_r;
   logic [7:0]         cnt_r;
   logic               ovf_r;
   logic               mixed_r;
   logic               mode_r;
   logic [acc_w-1:0]   out_sum_r;
   logic [7:0]         out_count_r;
   logic               out_overflow_r;
   logic               out_mixed_r;

   logic               accept_s;
   logic               first_s;
   logic               mode_s;
   logic [acc_w-1:0]   ext_s;
   logic [acc_w:0]     sum_s;
   logic               ovf_s;
   logic [acc_w-1:0]   acc_next_s;
   logic [7:0]         cnt_next_s;
   logic               ovf_next_s;
   logic               mixed_next_s;

`ifdef PRODUCT_ACC_SATURATE_EN
   // Clamp target: unsigned groups pin high; signed groups pin toward the addend's sign.
   function automatic logic [acc_w-1:0] clamp_value(input logic signed_mode, input logic addend_neg);
      if (!signed_mode) begin
         return {acc_w{1'b1}};
      end else if (!addend_neg) begin
         return {1'b0, {(acc_w-1){1'b1}}};
      end else begin
         return {1'b1, {(acc_w-1){1'b0}}};
      end
   endfunction
`endif

   assign accept_s = bus.in_valid && in_ready_r;

   // Per-beat extension, add, overflow detection and sticky flag updates
   always_comb begin
      first_s      = (cnt_r == 8'd0);
      mode_s       = first_s ? bus.in_signed : mode_r;
      ext_s        = {{EXT_W{bus.in_signed & bus.in_prod[2*n-1]}}, bus.in_prod};
      sum_s        = {1'b0, acc_r} + {1'b0, ext_s};
      if (mode_s) begin
         ovf_s = (acc_r[acc_w-1] == ext_s[acc_w-1]) && (sum_s[acc_w-1] != acc_r[acc_w-1]);
      end else begin
         ovf_s = sum_s[acc_w];
      end
`ifdef PRODUCT_ACC_SATURATE_EN
      acc_next_s   = ovf_s ? clamp_value(mode_s, ext_s[acc_w-1]) : sum_s[acc_w-1:0];
`else
      acc_next_s   = sum_s[acc_w-1:0];
`endif
      cnt_next_s   = (cnt_r == 8'd255) ? 8'd255 : cnt_r + 8'd1;
      ovf_next_s   = ovf_r | ovf_s;
      mixed_next_s = mixed_r | (!first_s && (bus.in_signed != mode_r));
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_ACCUM: begin
            if (accept_s && bus.in_last) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_valid_r && bus.out_ready) begin
               state_next_s = ST_ACCUM;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_ACCUM;
         end
      endcase
   end

   // State register with handshake outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_ACCUM;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == ST_ACCUM);
         out_valid_r <= (state_next_s == ST_HOLD);
      end
   end

   // Accumulator, group state and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r          <= {acc_w{1'b0}};
         cnt_r          <= 8'd0;
         ovf_r          <= 1'b0;
         mixed_r        <= 1'b0;
         mode_r         <= 1'b0;
         out_sum_r      <= {acc_w{1'b0}};
         out_count_r    <= 8'd0;
         out_overflow_r <= 1'b0;
         out_mixed_r    <= 1'b0;
      end else if (accept_s) begin
         if (bus.in_last) begin
            out_sum_r      <= acc_next_s;
            out_count_r    <= cnt_next_s;
            out_overflow_r <= ovf_next_s;
            out_mixed_r    <= mixed_next_s;
            acc_r          <= {acc_w{1'b0}};
            cnt_r          <= 8'd0;
            ovf_r          <= 1'b0;
            mixed_r        <= 1'b0;
            mode_r         <= 1'b0;
         end else begin
            acc_r          <= acc_next_s;
            cnt_r          <= cnt_next_s;
            ovf_r          <= ovf_next_s;
            mixed_r        <= mixed_next_s;
            mode_r         <= mode_s;
         end
      end else begin
         acc_r          <= acc_r;
         out_sum_r      <= out_sum_r;
      end
   end

   assign bus.in_ready     = in_ready_r;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_sum      = out_sum_r;
   assign bus.out_count    = out_count_r;
   assign bus.out_overflow = out_overflow_r;
   assign bus.out_mixed    = out_mixed_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator (n=4, acc_w=12) against an arithmetic group model.
module tb_product_accumulator;

   localparam int N     = 4;
   localparam int ACC_W = 12;
   localparam int MOD   = 1 << ACC_W;
   localparam int SMAX  = (1 << (ACC_W-1)) - 1;
   localparam int SMIN  = -(1 << (ACC_W-1));

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   logic [7:0] g_prod [0:299];
   logic       g_sgn  [0:299];
   int         g_len;

   product_accumulator_if #(.n(N), .acc_w(ACC_W)) bus ();

   product_accumulator #(.n(N), .acc_w(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Group result computed from value ranges: the sum leaves the representable range -> overflow
   task automatic model_group(output int e_sum, output int e_cnt, output bit e_ovf, output bit e_mix);
      int  acc, e, a, b, s, sat;
      bit  mode, o;
      acc = 0; e_cnt = 0; e_ovf = 0; e_mix = 0; mode = 0;
      for (int i = 0; i < g_len; i++) begin
         e = int'(g_prod[i]);
         if (g_sgn[i] && g_prod[i] >= 8'd128) e = e + MOD - 256;
         if (i == 0) mode = g_sgn[i];
         else if (g_sgn[i] != mode) e_mix = 1;
         if (!mode) begin
            s = acc + e;
            o = (s >= MOD);
            sat = MOD - 1;
         end else begin
            a = (acc > SMAX) ? acc - MOD : acc;
            b = (e > SMAX) ? e - MOD : e;
            s = a + b;
            o = (s > SMAX) || (s < SMIN);
            sat = (b >= 0) ? SMAX : MOD + SMIN;
         end
         if (o) e_ovf = 1;
`ifdef PRODUCT_ACC_SATURATE_EN
         acc = o ? sat : ((s % MOD) + MOD) % MOD;
`else
         acc = ((s % MOD) + MOD) % MOD;
`endif
         if (e_cnt < 255) e_cnt++;
      end
      e_sum = acc;
   endtask

   task automatic check_result(input string tag, input int e_sum, input int e_cnt, input bit e_ovf, input bit e_mix);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_sum"}, 32'(bus.out_sum), 32'(e_sum));
      check({tag, "_count"}, 32'(bus.out_count), 32'(e_cnt));
      check({tag, "_ovf"}, 32'(bus.out_overflow), 32'(e_ovf));
      check({tag, "_mixed"}, 32'(bus.out_mixed), 32'(e_mix));
   endtask

   // Stream the stored group, check the result, hold it for hold_cycles, then hand it off
   task automatic run_group(input string tag, input int hold_cycles, input bit gaps,
                            output int e_sum, output int e_cnt, output bit e_ovf, output bit e_mix);
      model_group(e_sum, e_cnt, e_ovf, e_mix);
      for (int i = 0; i < g_len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus.in_valid  = 1'b1;
         bus.in_prod   = g_prod[i];
         bus.in_signed = g_sgn[i];
         bus.in_last   = (i == g_len - 1);
         check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
         check({tag, "_nov"}, 32'(bus.out_valid), 32'd0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_prod  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      check_result(tag, e_sum, e_cnt, e_ovf, e_mix);
      for (int h = 0; h < hold_cycles; h++) begin
         @(posedge clk); #1;
         check_result({tag, "_hold"}, e_sum, e_cnt, e_ovf, e_mix);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic fill(input int len, input logic [7:0] p, input logic sg);
      g_len = len;
      for (int i = 0; i < len; i++) begin
         g_prod[i] = p;
         g_sgn[i]  = sg;
      end
   endtask

   initial begin
      int  s, c, len;
      bit  o, m, base;
      bus.in_valid  = 1'b0;
      bus.in_prod   = 8'd0;
      bus.in_signed = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum", 32'(bus.out_sum), 32'd0);
      check("rst_count", 32'(bus.out_count), 32'd0);
      check("rst_flags", {30'd0, bus.out_overflow, bus.out_mixed}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill(3, 8'hE1, 1'b0);
      run_group("unsigned", 0, 0, s, c, o, m);
      check("plan_unsigned_sum", 32'(s), 32'd675);

      fill(3, 8'hC8, 1'b1);
      g_prod[2] = 8'h40;
      run_group("signed", 1, 0, s, c, o, m);
      check("plan_signed_sum", 32'(s), 32'hFD0);

      fill(19, 8'hE1, 1'b0);
      run_group("uovf", 0, 0, s, c, o, m);
`ifdef PRODUCT_ACC_SATURATE_EN
      check("plan_uovf_sum", 32'(s), 32'hFFF);
`else
      check("plan_uovf_sum", 32'(s), 32'd179);
`endif

      fill(2, 8'hFF, 1'b0);
      g_sgn[1] = 1'b1;
      run_group("mixed", 0, 0, s, c, o, m);

      fill(2, 8'h7F, 1'b1);
      run_group("backpressure", 5, 0, s, c, o, m);

      fill(260, 8'h01, 1'b0);
      run_group("cnt_sat", 0, 0, s, c, o, m);
      check("plan_cnt_sat", 32'(c), 32'd255);

      fill(1, 8'h80, 1'b1);
      run_group("single", 0, 0, s, c, o, m);

      for (int t = 0; t < 40; t++) begin
         len  = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
         base = 1'($urandom);
         g_len = len;
         for (int i = 0; i < len; i++) begin
            g_prod[i] = 8'($urandom);
            g_sgn[i]  = ($urandom_range(0, 7) == 0) ? ~base : base;
         end
         run_group("rand", $urandom_range(0, 3), 1, s, c, o, m);
      end

      // Reset mid-group: two beats in, then an asynchronous reset pulse
      bus.in_valid  = 1'b1;
      bus.in_prod   = 8'h33;
      bus.in_signed = 1'b0;
      bus.in_last   = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(bus.in_ready), 32'd1);
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_sum", 32'(bus.out_sum), 32'd0);
      check("arst_count", 32'(bus.out_count), 32'd0);
      check("arst_flags", {30'd0, bus.out_overflow, bus.out_mixed}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill(1, 8'h05, 1'b0);
      run_group("post_rst", 0, 0, s, c, o, m);
      check("plan_post_rst_sum", 32'(s), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
